counter_job_sched: RTL and testbench
====================================

# counter_job_sched

Job scheduler that sequences the shared 8-bit load/count/output counter on behalf of several requesters. Each requester submits a job (start value, increment count) over a valid/ready handshake. The scheduler grants one job at a time in round-robin order, loads the counter, lets it run for the requested number of increments, and captures the result with the counter's output enable. It returns the result over a per-requester valid/ready response channel. It sits between requester logic and the counter instance in the top level.

## Interface
- N_REQ, 2, number of requesters (2..8)
- CNT_W, 8, counter/data width
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  N_REQ  job request per requester
- req_ready  out  N_REQ  job accepted (one-hot, at most one bit)
- req_start  in  N_REQ*CNT_W  start value; requester i in slice [i*CNT_W +: CNT_W]
- req_len  in  N_REQ*CNT_W  number of increments (0 legal)
- rsp_valid  out  N_REQ  result available for requester i
- rsp_ready  in  N_REQ  requester consumes result
- rsp_data  out  CNT_W  result, shared by all requesters, valid with the asserted rsp_valid bit
- cnt_load_e  out  1  counter load enable
- cnt_out_e  out  1  counter output enable
- cnt_load_val  out  CNT_W  counter load value
- cnt_data  in  CNT_W  counter output
- busy  out  1  high in every state except IDLE

## Operation
- Counter contract:
  - cnt_load_e=1 at an edge → counter = cnt_load_val.
  - Otherwise counter increments by 1 mod 2^CNT_W every edge.
  - cnt_data is valid when cnt_out_e=1.
- FSM states: IDLE, LOAD, RUN, RESP.
- IDLE:
  - If any req_valid: the arbiter picks grant g; req_ready[g]=1 combinationally.
  - Latch start, len and id=g; go to LOAD.
  - Otherwise stay in IDLE.
- LOAD: cnt_load_e=1, cnt_load_val=latched start; rem ← len; go to RUN.
- RUN:
  - If rem≠0: rem ← rem−1.
  - If rem==0: cnt_out_e=1, capture cnt_data into the result register, go to RESP.
- RESP:
  - rsp_valid[id]=1; rsp_data=result, held stable.
  - On rsp_ready[id]: go to IDLE.
  - Other requesters' rsp_ready bits are ignored.
- Result = (start + len) mod 2^CNT_W. Wrap-around is natural counter wrap.
- Round-robin arbitration:
  - Search starts at index ptr.
  - On each grant, ptr ← (g+1) mod N_REQ.
  - ptr does not move without a grant.
- Requesters hold req_start/req_len stable while req_valid=1 and unaccepted. Withdrawal before acceptance is legal.
- req_ready is 0 in LOAD, RUN and RESP. Only one job is in flight.
- cnt_load_val = 0 whenever cnt_load_e = 0.

## Timing
- Cycle numbering: 0 = accept cycle (IDLE, req_valid&req_ready).
  - Cycle 1 = LOAD.
  - Cycles 2..2+len = RUN; capture in cycle 2+len.
  - rsp_valid from cycle 3+len.
- Accept-to-rsp_valid latency: len+3 cycles.
- Minimum spacing between accepts: len+4 cycles (zero-wait response).
- The next accept can happen in the cycle after the response handshake.
- cnt_load_e and cnt_out_e are single-cycle pulses per job.
- Reset (rst_n=0 at an edge), from any state:
  - state=IDLE, ptr=0, rem=0, result=0.
  - All outputs 0: req_ready, rsp_valid, rsp_data, cnt_*, busy.
- Reset mid-job drops the job with no response. The requester must resubmit.
- Simultaneous req_valid on several requesters: only the ptr-first requester is accepted; the others wait.

## Structure
- Package counter_sched_pkg:
  - state enum (IDLE, LOAD, RUN, RESP)
  - CNT_W default
  - a helper for the requester-slice index width (clog2(N_REQ))
- Sub-module rr_arbiter:
  - Parameter N_REQ.
  - Inputs: req vector, enable (grant taken), clk, rst_n.
  - Outputs: one-hot grant, grant index.
  - Owns ptr; ptr resets to 0.
- Top-level FSM, rem counter, job latches and result register live in counter_job_sched.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with req_valid=all ones → every output 0. First post-reset grant goes to requester 0.
- Single job, req0 start=0x10 len=5, rsp_ready=1:
  - cnt_load_e=1 with val 0x10 at cycle 1.
  - cnt_out_e=1 at cycle 7.
  - rsp_valid[0] at cycle 8, rsp_data=0x15.
- Wrap and zero length:
  - start=0xFE len=3 → rsp_data=0x01 at cycle 6.
  - start=0x42 len=0 → rsp_data=0x42 at cycle 3; cnt_out_e at cycle 2.
- Contention, N_REQ=2, both req_valid continuously high → grant order 0,1,0,1. Each response goes only to the granted requester.
- Backpressure: hold rsp_ready low for 4 cycles →
  - rsp_valid and rsp_data stable for all 4 cycles.
  - req_ready stays 0 and busy=1.
  - Accept resumes the cycle after the handshake.
- Reset mid-RUN, req1 start=0x20 len=10, rst_n low at cycle 6 →
  - All outputs 0 and no rsp_valid.
  - Resubmission completes with 0x2A.
  - ptr back to 0.

Source files
------------

// File: rtl/counter_job_sched_pkg.sv
// rtl/counter_job_sched_pkg.sv - shared types and parameters for the counter job scheduler
package counter_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int CNT_W_DEF = 8;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/counter_job_sched_if.sv
// rtl/counter_job_sched_if.sv - job request/response channels between requesters and scheduler
interface counter_job_sched_if #(
  parameter int N_REQ = 2,
  parameter int CNT_W = 8
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*CNT_W-1:0] req_start;
  logic [N_REQ*CNT_W-1:0] req_len;
  logic [N_REQ-1:0]       rsp_valid;
  logic [N_REQ-1:0]       rsp_ready;
  logic [CNT_W-1:0]       rsp_data;

  modport master (
    output req_valid, req_start, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_start, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/counter_job_sched_rr_arbiter.sv
// rtl/counter_job_sched_rr_arbiter.sv - round-robin arbiter, search starts at ptr
module rr_arbiter
  import counter_sched_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int IDX_W = idx_w(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             enable,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx
);

  localparam logic [IDX_W:0]   N_SUM = (IDX_W+1)'(N_REQ);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_REQ - 1);

  logic [IDX_W-1:0] ptr;
  logic [N_REQ-1:0] rot;
  logic [IDX_W:0]   off;
  logic [IDX_W:0]   sum;
  logic             found;

  // Rotate so that bit 0 is the requester at ptr, pick the first set bit, rotate back.
  always_comb begin
    rot   = N_REQ'({req, req} >> ptr);
    found = 1'b0;
    off   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = (IDX_W+1)'(k);
      end
    end
    sum = {1'b0, ptr} + off;
    if (sum >= N_SUM) begin
      sum = sum - N_SUM;
    end
    grant_idx = sum[IDX_W-1:0];
    grant     = found ? (N_REQ'(1) << grant_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (enable && found) begin
      ptr <= (grant_idx == LAST) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/counter_job_sched.sv
// rtl/counter_job_sched.sv - sequences one shared load/count/output counter for several requesters
module counter_job_sched
  import counter_sched_pkg::*;
#(
  parameter  int N_REQ = 2,
  parameter  int CNT_W = CNT_W_DEF,
  localparam int IDX_W = idx_w(N_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  counter_job_sched_if.slave  jobs,
  output logic                cnt_load_e,
  output logic                cnt_out_e,
  output logic [CNT_W-1:0]    cnt_load_val,
  input  logic [CNT_W-1:0]    cnt_data,
  output logic                busy
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] start_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] result;
  logic [IDX_W-1:0] id_q;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             take;
  logic [N_REQ-1:0] req_ready_c;
  logic [N_REQ-1:0] rsp_valid_c;
  logic [CNT_W-1:0] rsp_data_c;

  // Gated by rst_n so nothing is offered to requesters while reset is held.
  assign take = (state == IDLE) && rst_n && (|jobs.req_valid);

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (jobs.req_valid),
    .enable    (take),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (rem == '0) state_nxt = RESP;
      RESP:    if (jobs.rsp_ready[id_q]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready_c  = '0;
    rsp_valid_c  = '0;
    rsp_data_c   = '0;
    cnt_load_e   = 1'b0;
    cnt_out_e    = 1'b0;
    cnt_load_val = '0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        if (take) req_ready_c = grant;
      end
      LOAD: begin
        cnt_load_e   = 1'b1;
        cnt_load_val = start_q;
      end
      RUN: begin
        cnt_out_e = (rem == '0);
      end
      RESP: begin
        rsp_valid_c = N_REQ'(1) << id_q;
        rsp_data_c  = result;
      end
      default: ;
    endcase
  end

  assign jobs.req_ready = req_ready_c;
  assign jobs.rsp_valid = rsp_valid_c;
  assign jobs.rsp_data  = rsp_data_c;

  // Counter is loaded at the LOAD edge, so after len RUN cycles it holds start+len.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_q <= '0;
      len_q   <= '0;
      id_q    <= '0;
      rem     <= '0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            start_q <= jobs.req_start[grant_idx*CNT_W +: CNT_W];
            len_q   <= jobs.req_len[grant_idx*CNT_W +: CNT_W];
            id_q    <= grant_idx;
          end
        end
        LOAD: rem <= len_q;
        RUN: begin
          if (rem != '0) begin
            rem <= rem - CNT_W'(1);
          end else begin
            result <= cnt_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_job_sched.sv
// tb/tb_counter_job_sched.sv - directed self-checking bench for counter_job_sched
module tb_counter_job_sched;

  logic       clk;
  logic       rst_n;
  logic       cnt_load_e;
  logic       cnt_out_e;
  logic [7:0] cnt_load_val;
  logic [7:0] cnt_data;
  logic       busy;
  logic [7:0] cnt_q = 8'h00;
  int         n_tests = 0;
  int         n_fail = 0;

  counter_job_sched_if #(.N_REQ(2), .CNT_W(8)) ifc ();

  counter_job_sched #(.N_REQ(2), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .jobs         (ifc),
    .cnt_load_e   (cnt_load_e),
    .cnt_out_e    (cnt_out_e),
    .cnt_load_val (cnt_load_val),
    .cnt_data     (cnt_data),
    .busy         (busy)
  );

  // Behavioural model of the shared counter.
  always @(posedge clk) cnt_q <= cnt_load_e ? cnt_load_val : cnt_q + 8'd1;
  assign cnt_data = cnt_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int w;
    rst_n = 1'b0;
    ifc.req_valid = 2'b11;
    ifc.req_start = {8'h33, 8'h33};
    ifc.req_len   = {8'h01, 8'h01};
    ifc.rsp_ready = 2'b11;
    for (int c = 0; c < 3; c++) begin
      tick;
      n_tests++;
      if ({ifc.req_ready, ifc.rsp_valid, ifc.rsp_data, cnt_load_e, cnt_out_e, cnt_load_val, busy} !== 23'd0) begin
        n_fail++;
        $display("FAIL reset_outputs c=%0d: got rr=%b rv=%b rd=%h le=%b oe=%b lv=%h busy=%b, want all 0",
                 c, ifc.req_ready, ifc.rsp_valid, ifc.rsp_data, cnt_load_e, cnt_out_e, cnt_load_val, busy);
      end
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (ifc.req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_first_grant: got %b want 01", ifc.req_ready);
    end
    tick;
    ifc.req_valid = 2'b00;
    w = 0;
    while (ifc.rsp_valid == 2'b00 && w < 10) begin tick; w++; end
    n_tests++;
    if (ifc.rsp_valid !== 2'b01 || ifc.rsp_data !== 8'h34 || w != 3) begin
      n_fail++;
      $display("FAIL reset_drain: got rv=%b rd=%h wait=%0d want rv=01 rd=34 wait=3", ifc.rsp_valid, ifc.rsp_data, w);
    end
    tick;
  endtask

  task automatic test_single;
    ifc.req_valid = 2'b01;
    ifc.req_start[7:0] = 8'h10;
    ifc.req_len[7:0]   = 8'd5;
    ifc.rsp_ready = 2'b11;
    #1;
    n_tests++;
    if (ifc.req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL single_accept: got %b want 01", ifc.req_ready);
    end
    for (int c = 1; c <= 9; c++) begin
      tick;
      if (c == 1) ifc.req_valid = 2'b00;
      n_tests++;
      if (cnt_load_e !== (c == 1) || cnt_load_val !== (c == 1 ? 8'h10 : 8'h00)) begin
        n_fail++;
        $display("FAIL single_load c=%0d: got le=%b lv=%h", c, cnt_load_e, cnt_load_val);
      end
      n_tests++;
      if (cnt_out_e !== (c == 7)) begin
        n_fail++;
        $display("FAIL single_out_e c=%0d: got %b want %b", c, cnt_out_e, (c == 7));
      end
      n_tests++;
      if (ifc.rsp_valid !== (c == 8 ? 2'b01 : 2'b00) || ifc.rsp_data !== (c == 8 ? 8'h15 : 8'h00)) begin
        n_fail++;
        $display("FAIL single_rsp c=%0d: got rv=%b rd=%h", c, ifc.rsp_valid, ifc.rsp_data);
      end
      n_tests++;
      if (busy !== (c <= 8)) begin
        n_fail++;
        $display("FAIL single_busy c=%0d: got %b want %b", c, busy, (c <= 8));
      end
    end
  endtask

  task automatic test_wrap_zero;
    logic [7:0] st  [2];
    logic [7:0] ln  [2];
    logic [7:0] ex  [2];
    st = '{8'hFE, 8'h42};
    ln = '{8'd3, 8'd0};
    ex = '{8'h01, 8'h42};
    for (int v = 0; v < 2; v++) begin
      ifc.req_valid = 2'b01;
      ifc.req_start[7:0] = st[v];
      ifc.req_len[7:0]   = ln[v];
      #1;
      n_tests++;
      if (ifc.req_ready !== 2'b01) begin
        n_fail++;
        $display("FAIL wrap_accept v=%0d: got %b want 01", v, ifc.req_ready);
      end
      for (int c = 1; c <= int'(ln[v]) + 4; c++) begin
        tick;
        if (c == 1) ifc.req_valid = 2'b00;
        n_tests++;
        if (cnt_out_e !== (c == int'(ln[v]) + 2)) begin
          n_fail++;
          $display("FAIL wrap_out_e v=%0d c=%0d: got %b", v, c, cnt_out_e);
        end
        if (c == int'(ln[v]) + 3) begin
          n_tests++;
          if (ifc.rsp_valid !== 2'b01 || ifc.rsp_data !== ex[v]) begin
            n_fail++;
            $display("FAIL wrap_rsp v=%0d: got rv=%b rd=%h want rv=01 rd=%h", v, ifc.rsp_valid, ifc.rsp_data, ex[v]);
          end
        end
      end
    end
  endtask

  task automatic test_contention;
    logic [7:0] ex [2];
    int         ln [2];
    int         w;
    int         lat;
    int         g;
    ex = '{8'h02, 8'h81};
    ln = '{2, 1};
    rst_n = 1'b0;
    ifc.req_valid = 2'b00;
    tick;
    rst_n = 1'b1;
    ifc.req_valid = 2'b11;
    ifc.req_start = {8'h80, 8'h00};
    ifc.req_len   = {8'd1, 8'd2};
    ifc.rsp_ready = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      g = k % 2;
      w = 0;
      while (ifc.req_ready == 2'b00 && w < 10) begin tick; w++; end
      n_tests++;
      if (ifc.req_ready !== (2'b01 << g) || w != 0) begin
        n_fail++;
        $display("FAIL cont_grant k=%0d: got %b wait=%0d want %b wait=0", k, ifc.req_ready, w, 2'b01 << g);
      end
      lat = 0;
      do begin tick; lat++; end while (ifc.rsp_valid == 2'b00 && lat < 20);
      n_tests++;
      if (ifc.rsp_valid !== (2'b01 << g) || ifc.rsp_data !== ex[g] || lat != ln[g] + 3) begin
        n_fail++;
        $display("FAIL cont_rsp k=%0d: got rv=%b rd=%h lat=%0d want rv=%b rd=%h lat=%0d",
                 k, ifc.rsp_valid, ifc.rsp_data, lat, 2'b01 << g, ex[g], ln[g] + 3);
      end
      if (k == 3) ifc.req_valid = 2'b00;
      tick;
    end
  endtask

  task automatic test_backpressure;
    int w;
    ifc.req_valid = 2'b10;
    ifc.req_start[15:8] = 8'h05;
    ifc.req_len[15:8]   = 8'd0;
    ifc.rsp_ready = 2'b00;
    #1;
    n_tests++;
    if (ifc.req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_accept: got %b want 10", ifc.req_ready);
    end
    tick;
    ifc.req_valid = 2'b01;
    ifc.req_start[7:0] = 8'h07;
    ifc.req_len[7:0]   = 8'd1;
    ifc.rsp_ready = 2'b01;
    tick;
    tick;
    for (int c = 0; c < 4; c++) begin
      n_tests++;
      if (ifc.rsp_valid !== 2'b10 || ifc.rsp_data !== 8'h05) begin
        n_fail++;
        $display("FAIL bp_hold c=%0d: got rv=%b rd=%h want rv=10 rd=05", c, ifc.rsp_valid, ifc.rsp_data);
      end
      n_tests++;
      if (ifc.req_ready !== 2'b00 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_blocked c=%0d: got rr=%b busy=%b want rr=00 busy=1", c, ifc.req_ready, busy);
      end
      tick;
    end
    ifc.rsp_ready = 2'b10;
    #1;
    n_tests++;
    if (ifc.rsp_valid !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_still_valid: got %b want 10", ifc.rsp_valid);
    end
    tick;
    n_tests++;
    if (ifc.req_ready !== 2'b01 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_resume: got rr=%b busy=%b want rr=01 busy=0", ifc.req_ready, busy);
    end
    tick;
    ifc.req_valid = 2'b00;
    ifc.rsp_ready = 2'b11;
    w = 0;
    while (ifc.rsp_valid == 2'b00 && w < 10) begin tick; w++; end
    n_tests++;
    if (ifc.rsp_valid !== 2'b01 || ifc.rsp_data !== 8'h08) begin
      n_fail++;
      $display("FAIL bp_second: got rv=%b rd=%h want rv=01 rd=08", ifc.rsp_valid, ifc.rsp_data);
    end
    tick;
  endtask

  task automatic test_reset_mid_run;
    int w;
    ifc.req_valid = 2'b10;
    ifc.req_start[15:8] = 8'h20;
    ifc.req_len[15:8]   = 8'd10;
    ifc.rsp_ready = 2'b11;
    #1;
    n_tests++;
    if (ifc.req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_accept: got %b want 10", ifc.req_ready);
    end
    for (int c = 1; c <= 6; c++) begin
      tick;
      if (c == 1) ifc.req_valid = 2'b00;
    end
    rst_n = 1'b0;
    tick;
    n_tests++;
    if ({ifc.req_ready, ifc.rsp_valid, ifc.rsp_data, cnt_load_e, cnt_out_e, cnt_load_val, busy} !== 23'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got rr=%b rv=%b rd=%h le=%b oe=%b lv=%h busy=%b, want all 0",
               ifc.req_ready, ifc.rsp_valid, ifc.rsp_data, cnt_load_e, cnt_out_e, cnt_load_val, busy);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick;
      n_tests++;
      if (ifc.rsp_valid !== 2'b00 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_no_rsp c=%0d: got rv=%b busy=%b want rv=00 busy=0", c, ifc.rsp_valid, busy);
      end
    end
    ifc.req_valid = 2'b11;
    ifc.req_start[7:0] = 8'h00;
    ifc.req_len[7:0]   = 8'd0;
    #1;
    n_tests++;
    if (ifc.req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_ptr_zero: got %b want 01", ifc.req_ready);
    end
    tick;
    ifc.req_valid = 2'b10;
    w = 0;
    while (ifc.rsp_valid == 2'b00 && w < 10) begin tick; w++; end
    n_tests++;
    if (ifc.rsp_valid !== 2'b01 || ifc.rsp_data !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_req0: got rv=%b rd=%h want rv=01 rd=00", ifc.rsp_valid, ifc.rsp_data);
    end
    tick;
    n_tests++;
    if (ifc.req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_resubmit_accept: got %b want 10", ifc.req_ready);
    end
    tick;
    ifc.req_valid = 2'b00;
    w = 0;
    while (ifc.rsp_valid == 2'b00 && w < 20) begin tick; w++; end
    n_tests++;
    if (ifc.rsp_valid !== 2'b10 || ifc.rsp_data !== 8'h2A || w != 12) begin
      n_fail++;
      $display("FAIL mid_resubmit_rsp: got rv=%b rd=%h wait=%0d want rv=10 rd=2a wait=12", ifc.rsp_valid, ifc.rsp_data, w);
    end
    tick;
  endtask

  initial begin
    rst_n = 1'b0;
    ifc.req_valid = 2'b00;
    ifc.req_start = '0;
    ifc.req_len   = '0;
    ifc.rsp_ready = 2'b00;
    test_reset;
    test_single;
    test_wrap_zero;
    test_contention;
    test_backpressure;
    test_reset_mid_run;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
